// File: rtl/ps2_rx.sv
`timescale 1ns/1ps
// PS/2 device-to-host receiver: synchronizes and deglitches the raw lines, then deframes 11-bit frames.
// Define PS2_RX_PARITY_EN to reject bytes failing odd parity (parity_err); otherwise parity is ignored.
module ps2_rx #(
    parameter int          FILTER_LEN = 4,
    parameter logic [15:0] TIMEOUT    = 16'd5000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       strobe_out,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int              FCW          = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0]  FILT_LAST    = FCW'(FILTER_LEN - 1);
    localparam logic [15:0]     TIMEOUT_LAST = TIMEOUT - 16'd1;

`ifdef PS2_RX_PARITY_EN
    localparam bit CHECK_PARITY = 1'b1;
`else
    localparam bit CHECK_PARITY = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Both lines are asynchronous; the synchronizers idle high like the bus.
    logic [1:0] clk_sync_reg;
    logic [1:0] data_sync_reg;
    logic       clk_s;
    logic       data_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    // The filtered clock only follows a level held for FILTER_LEN consecutive samples.
    logic           filt_reg;
    logic           filt_prev_reg;
    logic [FCW-1:0] filt_cnt_reg;
    logic           fall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_reg      <= 1'b1;
            filt_prev_reg <= 1'b1;
            filt_cnt_reg  <= '0;
        end else begin
            filt_prev_reg <= filt_reg;
            if (clk_s == filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FILT_LAST) begin
                filt_reg     <= clk_s;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    assign fall = filt_prev_reg & ~filt_reg;

    state_t      state_reg,    state_next;
    logic [2:0]  bit_cnt_reg,  bit_cnt_next;
    logic [7:0]  shift_reg,    shift_next;
    logic        parity_reg,   parity_next;
    logic [7:0]  scancode_reg, scancode_next;
    logic        strobe_reg,   strobe_next;
    logic        perr_reg,     perr_next;
    logic        ferr_reg,     ferr_next;
    logic [15:0] timer_reg,    timer_next;
    logic        parity_ok;
    logic        timeout_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            parity_reg   <= 1'b0;
            scancode_reg <= 8'h00;
            strobe_reg   <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            timer_reg    <= 16'd0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            scancode_reg <= scancode_next;
            strobe_reg   <= strobe_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            timer_reg    <= timer_next;
        end
    end

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign parity_ok   = ^{shift_reg, parity_reg};
    assign timeout_hit = (state_reg != IDLE) && (timer_reg == TIMEOUT_LAST);

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        scancode_next = scancode_reg;
        strobe_next   = 1'b0;
        perr_next     = 1'b0;
        ferr_next     = 1'b0;

        if ((state_reg == IDLE) || fall) begin
            timer_next = 16'd0;
        end else if (timer_reg != TIMEOUT_LAST) begin
            timer_next = timer_reg + 16'd1;
        end else begin
            timer_next = timer_reg;
        end

        // A fall takes priority over a coincident timeout.
        if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (!data_s) begin
                        state_next   = DATA;
                        bit_cnt_next = 3'd0;
                        shift_next   = 8'h00;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
                DATA: begin
                    shift_next   = {data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = data_s;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (!data_s) begin
                        ferr_next = 1'b1;
                    end else if (CHECK_PARITY && !parity_ok) begin
                        perr_next = 1'b1;
                    end else begin
                        scancode_next = shift_reg;
                        strobe_next   = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end else if (timeout_hit) begin
            state_next = IDLE;
            ferr_next  = 1'b1;
        end
    end

    assign scancode   = scancode_reg;
    assign strobe_out = strobe_reg;
    assign parity_err = perr_reg;
    assign frame_err  = ferr_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for ps2_rx: each frame queues its expected strobe/error event and a monitor
// pops and compares one entry for every output pulse. 2 us system clock, 12.5 kHz PS/2 clock.
module tb_ps2_rx;

    localparam logic [2:0] EV_STROBE = 3'b100;
    localparam logic [2:0] EV_PERR   = 3'b010;
    localparam logic [2:0] EV_FERR   = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] code;
    } evt_t;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       strobe_out;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    evt_t       exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] last_good   = 8'h00;

    ps2_rx #(
        .FILTER_LEN(4),
        .TIMEOUT   (16'd100)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scancode  (scancode),
        .strobe_out(strobe_out),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #1000 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_evt(input logic [2:0] kind, input logic [7:0] code);
        evt_t e;
        e.kind = kind;
        e.code = code;
        exp_q.push_back(e);
    endtask

    // Sends the first nbits of {stop, parity, data, start}, LSB first, at 40 cycles per bit.
    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop,
                             input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(8);
            ps2_clk = 1'b0;
            if (glitch) begin
                wait_cyc(8);
                ps2_clk = 1'b1;
                wait_cyc(2);
                ps2_clk = 1'b0;
                wait_cyc(10);
            end else begin
                wait_cyc(20);
            end
            ps2_clk = 1'b1;
            if (glitch) begin
                wait_cyc(9);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(1);
            end else begin
                wait_cyc(12);
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic settle(input string tag);
        wait_cyc(20);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_scancode"}, scancode, last_good);
    endtask

    task automatic send_good(input logic [7:0] d, input bit glitch);
        push_evt(EV_STROBE, d);
        last_good = d;
        send_bits(d, ~^d, 1'b1, 11, glitch);
    endtask

    initial begin : monitor
        evt_t       ev;
        logic [2:0] kind;
        forever begin
            @(negedge clock);
            kind = {strobe_out, parity_err, frame_err};
            if (reset_n && (kind != 3'b000)) begin
                if ((kind != EV_STROBE) && (kind != EV_PERR) && (kind != EV_FERR))
                    check("pulse_onehot", kind, EV_FERR);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", kind, 3'b000);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", kind, ev.kind);
                    check("pulse_scancode", scancode, ev.code);
                end
            end
        end
    end

    initial begin : stimulus
        wait_cyc(5);
        check("rst_scancode", scancode, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {strobe_out, parity_err, frame_err}, 3'b000);
        reset_n = 1'b1;
        wait_cyc(10);

        send_good(8'h1C, 1'b0);
        settle("first_1c");

        send_good(8'hF0, 1'b0);
        send_good(8'h1C, 1'b0);
        settle("b2b");

        send_good(8'hF0, 1'b0);
        settle("pre_par");
`ifdef PS2_RX_PARITY_EN
        push_evt(EV_PERR, last_good);
`else
        push_evt(EV_STROBE, 8'h1C);
        last_good = 8'h1C;
`endif
        send_bits(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        settle("bad_parity");

        push_evt(EV_FERR, last_good);
        send_bits(8'h77, ~^8'h77, 1'b0, 11, 1'b0);
        settle("bad_stop");
        send_good(8'h32, 1'b0);
        settle("after_stop_32");

        push_evt(EV_FERR, last_good);
        ps2_data = 1'b1;
        wait_cyc(8);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(12);
        settle("bad_start");

        push_evt(EV_FERR, last_good);
        send_bits(8'h5A, 1'b1, 1'b1, 5, 1'b0);
        check("busy_partial", busy, 1'b1);
        wait_cyc(150);
        check("busy_timeout", busy, 1'b0);
        send_good(8'h5A, 1'b0);
        settle("after_timeout_5a");

        send_good(8'hA5, 1'b1);
        settle("glitch_a5");
        send_good(8'h3C, 1'b1);
        settle("glitch_3c");

        send_bits(8'h3C, ~^8'h3C, 1'b1, 4, 1'b1);
        check("busy_pre_reset", busy, 1'b1);
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_scancode", scancode, 8'h00);
        last_good = 8'h00;
        reset_n   = 1'b1;
        wait_cyc(30);
        check("post_rst_busy", busy, 1'b0);
        send_good(8'h1C, 1'b1);
        settle("post_rst_1c");

        wait_cyc(20);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive identical ps2_clk samples required before the filtered clock changes.
REQ-002 SHALL have parameter TIMEOUT, default 16'd5000: clock cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 clock  input  1  system clock; all state on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous.
REQ-007 scancode  output  8  last good received byte; feeds the scancode converter's scancode input.
REQ-008 strobe_out  output  1  one-cycle pulse, scancode newly valid; feeds the converter's strobe_in.
REQ-009 parity_err  output  1  one-cycle pulse on a parity failure.
REQ-010 frame_err  output  1  one-cycle pulse on bad start, bad stop or timeout.
REQ-011 busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers before any use.
REQ-013 SHALL filter synchronized ps2_clk: filtered value changes only after FILTER_LEN consecutive equal samples; shorter glitches are ignored.
REQ-014 SHALL detect a fall as filtered clock 1->0 and sample synchronized ps2_data in that cycle.
REQ-015 States: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: fall with data=0 -> DATA, bit count 0; fall with data=1 -> frame_err pulse, stay IDLE.
REQ-017 DATA: each fall shifts data in LSB-first; after the 8th bit -> PARITY.
REQ-018 PARITY: fall captures parity bit -> STOP.
REQ-019 STOP: fall with data=1 and parity good -> scancode loaded, strobe_out pulsed, -> IDLE.
REQ-020 STOP: fall with data=0 -> frame_err pulse, scancode unchanged, no strobe, -> IDLE.
REQ-021 Parity good SHALL mean the 8 data bits plus parity bit contain an odd number of ones.
REQ-022 strobe_out SHALL assert exactly one cycle, in the cycle after the stop-bit fall is detected.
REQ-023 scancode SHALL hold its value until the next good frame.
REQ-024 Timeout counter SHALL clear on every fall and in IDLE, saturate, and when it reaches TIMEOUT-1 outside IDLE force IDLE and pulse frame_err; partial byte discarded.
REQ-025 If a fall and timeout coincide, the fall SHALL win (counter clears, frame continues).
REQ-026 At most one of strobe_out, parity_err, frame_err SHALL be high in any cycle.

Reset
REQ-027 On reset_n low: state IDLE, bit count 0, shift register 0, scancode 8'h00, strobe_out/parity_err/frame_err 0, busy 0, synchronizers and filtered clock 1 (idle line level), timeout counter 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no strobe or error pulse after release.

Configuration
REQ-029 Macro PS2_RX_PARITY_EN defined: parity failure in STOP discards the byte, pulses parity_err, no strobe, -> IDLE.
REQ-030 PS2_RX_PARITY_EN undefined: parity bit sampled but ignored, any frame with good start/stop strobes, parity_err tied 0.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1, 12.5 kHz ps2_clk -> scancode=8'h1C, one strobe_out pulse, no errors.
REQ-032 Frames F0 (parity 1) then 1C back-to-back -> two strobes, scancode 8'hF0 then 8'h1C.
REQ-033 Frame 0x1C with parity 1 -> with PS2_RX_PARITY_EN: parity_err pulse, scancode unchanged, no strobe; without: strobe, scancode=8'h1C.
REQ-034 Frame with stop bit 0 -> frame_err pulse, no strobe; following good 0x32 frame received correctly.
REQ-035 ps2_clk stopped after 4 data bits for >TIMEOUT cycles -> frame_err pulse, busy low; next 0x5A frame received.
REQ-036 2-cycle ps2_clk glitches during a frame -> no extra bits; byte correct; reset_n pulsed mid-frame -> busy 0, no pulses.
